// File: rtl/wb_shared_slave_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared types and helpers for the Wishbone shared-slave arbiter.
//   arb_state_e    : controller states (IDLE, GRANT, ABORT)
//   TIMEOUT_CNT_W  : width of the saturating watchdog-abort counter
//   MAX_REQ        : largest master count the one-hot helper can encode
//   onehot2id      : one-hot vector to binary index
// ---------------------------------------------------------------------------
package wb_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ABORT = 2'd2
   } arb_state_e;

   localparam int TIMEOUT_CNT_W = 8;
   localparam int MAX_REQ       = 32;

   // Returns the index of the highest set bit; callers only pass one-hot or
   // all-zero vectors, for which this is the exact bit position (or 0).
   function automatic int onehot2id(input logic [MAX_REQ-1:0] oh);
      int id;
      id = 0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) id = i;
      end
      return id;
   endfunction

endpackage

// File: rtl/wb_shared_slave_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// wb_rr_pick
// Combinational round-robin picker. Searches the request vector starting at
// (i_last_id + 1) mod N_REQ and returns the first set bit.
// Ports:
//   i_req        : per-master request vector
//   i_last_id    : index of the most recently granted master
//   o_pick       : one-hot selection (all zero when nothing requests)
//   o_pick_id    : binary index of o_pick
//   o_pick_valid : at least one request present
// ---------------------------------------------------------------------------
module wb_rr_pick
   import wb_arbiter_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int N_ID_BITS = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0]     i_req,
   input  logic [N_ID_BITS-1:0] i_last_id,
   output logic [N_REQ-1:0]     o_pick,
   output logic [N_ID_BITS-1:0] o_pick_id,
   output logic                 o_pick_valid
);

   logic [N_REQ-1:0]     w_pick;
   logic                 w_found;
   logic [N_ID_BITS-1:0] w_idx;

   // Rotating scan; the modulo keeps the search correct for non-power-of-two
   // master counts.
   always_comb begin
      w_pick  = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_idx = N_ID_BITS'((int'(i_last_id) + 1 + i) % N_REQ);
         if (!w_found && i_req[w_idx]) begin
            w_pick[w_idx] = 1'b1;
            w_found       = 1'b1;
         end
      end
   end

   assign o_pick       = w_pick;
   assign o_pick_valid = w_found;
   assign o_pick_id    = N_ID_BITS'(onehot2id(MAX_REQ'(w_pick)));

endmodule

// File: rtl/wb_shared_slave_arbiter.sv
// ---------------------------------------------------------------------------
// wb_shared_slave_arbiter
// Shares one Wishbone slave between N_REQ masters. A registered one-hot grant
// is issued round-robin and held for the whole master cycle (CYC high). A
// per-strobe watchdog aborts a hung transfer by pulsing ERR back to the
// granted master for one cycle. Only mux select/gating controls are produced;
// address and data never pass through this block.
// Ports:
//   clk            : clock, all logic on the rising edge
//   rstn           : synchronous active-low reset
//   cyc_i / stb_i  : per-master CYC and STB
//   s_ack_i/s_err_i: ACK / ERR from the shared slave
//   gnt_o          : one-hot grant (registered)
//   gnt_valid_o    : any grant active
//   gnt_id_o       : index of the granted master, held after release
//   s_stb_en_o     : gate for the muxed slave STB (GRANT only)
//   m_err_o        : watchdog ERR to the granted master (ABORT only)
//   timeout_cnt_o  : saturating count of watchdog aborts
// ---------------------------------------------------------------------------
module wb_shared_slave_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int N_ID_BITS      = $clog2(N_REQ)
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [N_REQ-1:0]         cyc_i,
   input  logic [N_REQ-1:0]         stb_i,
   input  logic                     s_ack_i,
   input  logic                     s_err_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic                     gnt_valid_o,
   output logic [N_ID_BITS-1:0]     gnt_id_o,
   output logic                     s_stb_en_o,
   output logic                     m_err_o,
   output logic [TIMEOUT_CNT_W-1:0] timeout_cnt_o
);

   // A zero TIMEOUT_CYCLES disables the watchdog; keep the counter one bit
   // wide so the declaration stays legal.
   localparam int WDT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(TIMEOUT_CYCLES);

   arb_state_e               r_state;
   logic [N_REQ-1:0]         r_gnt;
   logic [N_ID_BITS-1:0]     r_gnt_id;
   logic [N_ID_BITS-1:0]     r_last_id;
   logic                     r_stb_en;
   logic                     r_m_err;
   logic [TIMEOUT_CNT_W-1:0] r_to_cnt;
   logic [WDT_W-1:0]         r_wdt;

   logic [N_REQ-1:0]         w_pick;
   logic [N_ID_BITS-1:0]     w_pick_id;
   logic                     w_pick_valid;
   logic                     w_cyc_g;
   logic                     w_stb_g;
   logic                     w_slave_resp;
   logic                     w_timeout;

   wb_rr_pick #(
      .N_REQ     (N_REQ),
      .N_ID_BITS (N_ID_BITS)
   ) u_rr_pick (
      .i_req        (cyc_i),
      .i_last_id    (r_last_id),
      .o_pick       (w_pick),
      .o_pick_id    (w_pick_id),
      .o_pick_valid (w_pick_valid)
   );

   assign w_cyc_g      = cyc_i[r_gnt_id];
   assign w_stb_g      = stb_i[r_gnt_id];
   assign w_slave_resp = s_ack_i | s_err_i;

   // A slave response in the same cycle the limit is reached wins over the
   // abort, so the response terms are part of the timeout condition itself.
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_wdt == WDT_MAX) &&
                      w_stb_g && !w_slave_resp;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_gnt     <= '0;
         r_gnt_id  <= '0;
         r_last_id <= N_ID_BITS'(N_REQ - 1);
         r_stb_en  <= 1'b0;
         r_m_err   <= 1'b0;
         r_to_cnt  <= '0;
         r_wdt     <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_wdt <= '0;
               if (w_pick_valid) begin
                  r_gnt     <= w_pick;
                  r_gnt_id  <= w_pick_id;
                  r_last_id <= w_pick_id;
                  r_stb_en  <= 1'b1;
                  r_state   <= GRANT;
               end
            end

            GRANT: begin
               // Release is checked first so a master dropping CYC never
               // sees a spurious ERR.
               if (!w_cyc_g) begin
                  r_gnt    <= '0;
                  r_stb_en <= 1'b0;
                  r_wdt    <= '0;
                  r_state  <= IDLE;
               end else if (w_timeout) begin
                  r_stb_en <= 1'b0;
                  r_m_err  <= 1'b1;
                  r_wdt    <= '0;
                  if (r_to_cnt != '1) r_to_cnt <= r_to_cnt + TIMEOUT_CNT_W'(1);
                  r_state  <= ABORT;
               end else if (w_slave_resp || !w_stb_g) begin
                  r_wdt <= '0;
               end else if (r_wdt != WDT_MAX) begin
                  r_wdt <= r_wdt + WDT_W'(1);
               end
            end

            ABORT: begin
               // Single-cycle state; late slave responses here are ignored
               // because s_stb_en_o is already low for the ack mux.
               r_m_err <= 1'b0;
               r_wdt   <= '0;
               if (w_cyc_g) begin
                  r_stb_en <= 1'b1;
                  r_state  <= GRANT;
               end else begin
                  r_gnt   <= '0;
                  r_state <= IDLE;
               end
            end

            default: begin
               r_gnt    <= '0;
               r_stb_en <= 1'b0;
               r_m_err  <= 1'b0;
               r_wdt    <= '0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

   assign gnt_o         = r_gnt;
   assign gnt_valid_o   = |r_gnt;
   assign gnt_id_o      = r_gnt_id;
   assign s_stb_en_o    = r_stb_en;
   assign m_err_o       = r_m_err;
   assign timeout_cnt_o = r_to_cnt;

endmodule

// File: tb/tb_wb_shared_slave_arbiter.sv
module tb_wb_shared_slave_arbiter;

   localparam int N  = 4;
   localparam int TO = 8;

   logic         clk;
   logic         rstn;
   logic [N-1:0] m_cyc;
   logic [N-1:0] m_stb;
   logic         s_ack;
   logic         s_err;
   logic [N-1:0] gnt;
   logic         gnt_valid;
   logic [1:0]   gnt_id;
   logic         stb_en;
   logic         m_err;
   logic [7:0]   to_cnt;

   // standalone picker
   logic [N-1:0] p_req;
   logic [1:0]   p_last;
   logic [N-1:0] p_pick;
   logic [1:0]   p_id;
   logic         p_valid;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_n   = 0;

   typedef struct {
      int         cyc;
      logic [3:0] gnt;
      logic [1:0] id;
   } gexp_t;

   typedef struct {
      int         cyc;
      logic [3:0] gnt;
      int         cnt;
   } eexp_t;

   gexp_t gq[$];
   eexp_t eq[$];
   gexp_t ge;
   eexp_t ee;
   logic [N-1:0] prev_gnt = '0;

   wb_shared_slave_arbiter #(
      .N_REQ          (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .cyc_i         (m_cyc),
      .stb_i         (m_stb),
      .s_ack_i       (s_ack),
      .s_err_i       (s_err),
      .gnt_o         (gnt),
      .gnt_valid_o   (gnt_valid),
      .gnt_id_o      (gnt_id),
      .s_stb_en_o    (stb_en),
      .m_err_o       (m_err),
      .timeout_cnt_o (to_cnt)
   );

   wb_rr_pick #(.N_REQ(N)) u_pick (
      .i_req        (p_req),
      .i_last_id    (p_last),
      .o_pick       (p_pick),
      .o_pick_id    (p_id),
      .o_pick_valid (p_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_until(input int t);
      while (cyc_n < t) tick();
   endtask

   task automatic push_g(input int c, input logic [3:0] g, input logic [1:0] id);
      gexp_t x;
      x.cyc = c; x.gnt = g; x.id = id;
      gq.push_back(x);
   endtask

   task automatic push_e(input int c, input logic [3:0] g, input int cnt);
      eexp_t x;
      x.cyc = c; x.gnt = g; x.cnt = cnt;
      eq.push_back(x);
   endtask

   // Monitor: every new non-zero grant and every ERR cycle is matched
   // against the next queued expectation.
   always @(negedge clk) begin
      if (gnt !== prev_gnt && gnt !== '0) begin
         if (gq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL grant_unexpected: got gnt %b expected none (cycle %0d)", gnt, cyc_n);
         end else begin
            ge = gq.pop_front();
            chk("grant_cycle", cyc_n, ge.cyc);
            chk("grant_onehot", gnt, ge.gnt);
            chk("grant_id", gnt_id, ge.id);
            chk("grant_valid", gnt_valid, 1);
         end
      end
      prev_gnt = gnt;
      if (m_err === 1'b1) begin
         if (eq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL err_unexpected: got m_err 1 expected 0 (cycle %0d)", cyc_n);
         end else begin
            ee = eq.pop_front();
            chk("err_cycle", cyc_n, ee.cyc);
            chk("err_gnt_held", gnt, ee.gnt);
            chk("err_cnt", to_cnt, ee.cnt);
            chk("err_stb_en", stb_en, 0);
         end
      end
   end

   initial begin
      int e;
      int g;
      rstn  = 1'b0;
      m_cyc = 4'b1010;
      m_stb = '0;
      s_ack = 1'b0;
      s_err = 1'b0;

      // standalone picker vectors
      p_req = 4'b1010; p_last = 2'd3; #1;
      chk("pick_a", {p_valid, p_id, p_pick}, {1'b1, 2'd1, 4'b0010});
      p_req = 4'b1010; p_last = 2'd1; #1;
      chk("pick_b", {p_valid, p_id, p_pick}, {1'b1, 2'd3, 4'b1000});
      p_req = 4'b0001; p_last = 2'd0; #1;
      chk("pick_wrap", {p_valid, p_id, p_pick}, {1'b1, 2'd0, 4'b0001});
      p_req = 4'b1111; p_last = 2'd2; #1;
      chk("pick_all", {p_valid, p_id, p_pick}, {1'b1, 2'd3, 4'b1000});
      p_req = 4'b0000; p_last = 2'd1; #1;
      chk("pick_none", {p_valid, p_pick}, {1'b0, 4'b0000});

      // reset state, then first grant from reset release
      tick(); tick();
      chk("rst_gnt", gnt, 0);
      chk("rst_valid", gnt_valid, 0);
      chk("rst_id", gnt_id, 0);
      chk("rst_stb_en", stb_en, 0);
      chk("rst_err", m_err, 0);
      chk("rst_cnt", to_cnt, 0);
      rstn = 1'b1;
      push_g(cyc_n + 1, 4'b0010, 2'd1);
      tick_until(5);
      m_cyc = '0;
      tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tick();

      // round robin 0,1,2,3,0 with one idle cycle between grants
      e = cyc_n;
      m_cyc = 4'b1111;
      push_g(e + 1,  4'b0001, 2'd0);
      push_g(e + 5,  4'b0010, 2'd1);
      push_g(e + 9,  4'b0100, 2'd2);
      push_g(e + 13, 4'b1000, 2'd3);
      push_g(e + 17, 4'b0001, 2'd0);
      for (int m = 0; m < 4; m++) begin
         tick_until(e + 3 + 4 * m);
         m_cyc[m] = 1'b0;
         if (m == 0) begin
            tick();
            chk("gap_idle", gnt_valid, 0);
            m_cyc[0] = 1'b1;
         end
      end
      tick_until(e + 19);
      m_cyc = '0;
      tick(); tick();

      // no preemption: master 0 waits for master 2 to drop CYC
      e = cyc_n;
      m_cyc = 4'b0100;
      push_g(e + 1, 4'b0100, 2'd2);
      push_g(e + 7, 4'b0001, 2'd0);
      tick_until(e + 2);
      m_cyc[0] = 1'b1;
      tick_until(e + 4);
      chk("no_preempt", gnt, 4'b0100);
      tick_until(e + 5);
      m_cyc[2] = 1'b0;
      tick_until(e + 8);
      m_cyc = '0;
      tick(); tick();

      // watchdog: STB held from edge e+4 gives ERR after edge e+12
      e = cyc_n;
      m_cyc = 4'b0010;
      push_g(e + 1, 4'b0010, 2'd1);
      tick_until(e + 3);
      m_stb = 4'b0010;
      push_e(e + 12, 4'b0010, 1);
      tick_until(e + 13);
      chk("post_abort_stb_en", stb_en, 1);
      chk("post_abort_err", m_err, 0);
      chk("post_abort_gnt", gnt, 4'b0010);
      m_cyc = '0;
      m_stb = '0;
      tick(); tick();

      // ack arriving exactly when the limit is reached wins
      e = cyc_n;
      m_cyc = 4'b0100;
      push_g(e + 1, 4'b0100, 2'd2);
      tick_until(e + 1);
      m_stb = 4'b0100;
      tick_until(e + 9);
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      chk("ack_wins_err", m_err, 0);
      chk("ack_wins_cnt", to_cnt, 1);
      tick_until(e + 11);
      m_cyc = '0;
      m_stb = '0;
      tick(); tick();

      // 300 back-to-back aborts saturate the counter; last abort exits to IDLE
      e = cyc_n;
      g = e + 1;
      m_cyc = 4'b1000;
      m_stb = 4'b1000;
      push_g(g, 4'b1000, 2'd3);
      for (int j = 0; j < 300; j++)
         push_e(g + 9 + 10 * j, 4'b1000, (2 + j > 255) ? 255 : 2 + j);
      tick_until(g + 2999);
      m_cyc = '0;
      m_stb = '0;
      tick();
      chk("sat_cnt", to_cnt, 255);
      chk("abort_to_idle_gnt", gnt, 0);
      chk("abort_to_idle_err", m_err, 0);
      tick(); tick();

      // reset pulse while master 3 holds the grant
      e = cyc_n;
      m_cyc = 4'b1000;
      push_g(e + 1, 4'b1000, 2'd3);
      tick_until(e + 3);
      rstn = 1'b0;
      m_cyc = 4'b1001;
      tick();
      rstn = 1'b1;
      chk("midrst_gnt", gnt, 0);
      chk("midrst_err", m_err, 0);
      chk("midrst_cnt", to_cnt, 0);
      chk("midrst_stb_en", stb_en, 0);
      push_g(e + 5, 4'b0001, 2'd0);
      tick_until(e + 7);
      m_cyc = '0;
      tick(); tick(); tick();

      chk("grant_queue_drained", gq.size(), 0);
      chk("err_queue_drained", eq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
